fifo_rd_port_arbiter: RTL and testbench

Read-domain controller that shares the single read port of the asynchronous FIFO among NUM_REQ consumers. It sits in the rd_clk domain, downstream of the FIFO empty logic that consumes the synchronized write pointer. The block grants the port round-robin in bounded bursts, drives the FIFO pop, and steers returning read data and a valid strobe to the owning consumer.

---
 rtl/fifo_rd_port_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_rd_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_port_arbiter.sv
// rtl/fifo_rd_port_arbiter.sv - round-robin burst arbiter sharing the async FIFO read port
module fifo_rd_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic                  rd_empty,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [NUM_REQ-1:0]    valid_out,
   output logic                  busy
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]      BURST_MAX  = CW'(MAX_BURST);
   localparam logic [CW-1:0]      BURST_LAST = CW'(MAX_BURST - 1);
   localparam logic [OW-1:0]      LAST_INIT  = OW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [OW-1:0] owner, owner_nxt;
   logic [OW-1:0] last_winner, last_winner_nxt;
   logic [OW-1:0] owner_d;
   logic [CW-1:0] burst_cnt, burst_cnt_nxt;
   logic          rd_en_d;
   logic [OW-1:0] pick;
   logic          pick_ok;
   int            scan_idx;

   // Round-robin search: first requester after the previous winner, wrapping around.
   always_comb begin
      pick     = '0;
      pick_ok  = 1'b0;
      scan_idx = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         scan_idx = (int'(last_winner) + i) % NUM_REQ;
         if (!pick_ok && req[scan_idx]) begin
            pick_ok = 1'b1;
            pick    = OW'(scan_idx);
         end
      end
   end

   // Next-state logic plus grant/pop outputs; reset blanks the port in the reset cycle itself.
   always_comb begin
      state_nxt       = state;
      owner_nxt       = owner;
      last_winner_nxt = last_winner;
      burst_cnt_nxt   = burst_cnt;
      rd_en           = 1'b0;
      gnt             = '0;
      busy            = 1'b0;
      case (state)
         IDLE: begin
            if (pick_ok && !rd_empty) begin
               state_nxt       = BURST;
               owner_nxt       = pick;
               last_winner_nxt = pick;
               burst_cnt_nxt   = '0;
            end
         end
         BURST: begin
            gnt   = ONE << owner;
            busy  = 1'b1;
            rd_en = req[owner] && !rd_empty && (burst_cnt < BURST_MAX);
            if (rd_en) begin
               burst_cnt_nxt = burst_cnt + CW'(1);
            end
            // Leaving through IDLE every time guarantees a gap before the next owner.
            if ((rd_en && (burst_cnt == BURST_LAST)) || !req[owner] || rd_empty) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rd_rst) begin
         rd_en = 1'b0;
         gnt   = '0;
         busy  = 1'b0;
      end
   end

   // State registers, plus the one-cycle-delayed pop/owner that steer returning data.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state       <= IDLE;
         owner       <= '0;
         last_winner <= LAST_INIT;
         burst_cnt   <= '0;
         rd_en_d     <= 1'b0;
         owner_d     <= '0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         last_winner <= last_winner_nxt;
         burst_cnt   <= burst_cnt_nxt;
         rd_en_d     <= rd_en;
         owner_d     <= owner;
      end
   end

   assign valid_out = (ONE << owner_d) & {NUM_REQ{rd_en_d}};
   assign data_out  = rd_data;

endmodule

// File: tb/tb_fifo_rd_port_arbiter.sv
// tb/tb_fifo_rd_port_arbiter.sv - randomized and directed checks for the read-port arbiter
module tb_fifo_rd_port_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic          rd_empty;
   logic [DW-1:0] rd_data;
   logic          rd_en;
   logic [N-1:0]  gnt;
   logic [DW-1:0] data_out;
   logic [N-1:0]  valid_out;
   logic          busy;

   fifo_rd_port_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .DATA_WIDTH(DW)) dut (
      .rd_clk    (clk),
      .rd_rst    (rst),
      .req       (req),
      .rd_empty  (rd_empty),
      .rd_data   (rd_data),
      .rd_en     (rd_en),
      .gnt       (gnt),
      .data_out  (data_out),
      .valid_out (valid_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Environment FIFO: rd_data follows a pop by one cycle.
   logic [DW-1:0] fifo_q[$];
   logic          force_empty;
   logic [DW-1:0] wr_seq;
   int            underflows;

   // Values observed in the most recent cycle.
   logic          o_rd_en, o_busy, o_empty;
   logic [N-1:0]  o_gnt, o_valid;
   logic [DW-1:0] o_data;

   // Reference model: owner is -1 when nobody holds the port.
   int            m_owner, m_last, m_pops, m_vowner;
   logic [DW-1:0] m_vdata;
   logic          e_rd_en, e_busy, e_rst;
   logic [N-1:0]  e_gnt, e_valid;
   logic [DW-1:0] e_data;

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(wr_seq);
         wr_seq = wr_seq + 1'b1;
      end
   endtask

   // One clock cycle: sample DUT and model, clock, then advance FIFO and model.
   task automatic step();
      logic [DW-1:0] front;
      rd_empty = force_empty || (fifo_q.size() == 0);
      #1;
      o_rd_en = rd_en;
      o_busy  = busy;
      o_gnt   = gnt;
      o_valid = valid_out;
      o_data  = data_out;
      o_empty = rd_empty;
      e_rst   = rst;
      e_gnt   = (rst || m_owner < 0) ? '0 : (N'(1) << m_owner);
      e_busy  = !rst && (m_owner >= 0);
      e_rd_en = !rst && (m_owner >= 0) && req[m_owner] && !rd_empty && (m_pops < MB);
      e_valid = (m_vowner >= 0) ? (N'(1) << m_vowner) : '0;
      e_data  = m_vdata;
      front   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      @(posedge clk);
      #1;
      if (o_rd_en) begin
         if (fifo_q.size() > 0) rd_data = fifo_q.pop_front();
         else begin
            underflows++;
            rd_data = '0;
         end
      end
      if (e_rst) begin
         m_owner  = -1;
         m_last   = N - 1;
         m_pops   = 0;
         m_vowner = -1;
      end else begin
         m_vowner = e_rd_en ? m_owner : -1;
         if (e_rd_en) m_vdata = front;
         if (m_owner < 0) begin
            if (req != '0 && !o_empty) begin
               for (int k = 1; k <= N; k++)
                  if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
               m_last = m_owner;
               m_pops = 0;
            end
         end else begin
            if (e_rd_en) m_pops++;
            if ((e_rd_en && m_pops == MB) || !req[m_owner] || o_empty) m_owner = -1;
         end
      end
      rd_empty = force_empty || (fifo_q.size() == 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      step();
      step();
      rst = 1'b0;
      step();
      total++; if (o_gnt !== '0)   begin bad++; $display("FAIL reset_gnt got=%b exp=0000", o_gnt); end
      total++; if (o_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", o_rd_en); end
      total++; if (o_valid !== '0) begin bad++; $display("FAIL reset_valid got=%b exp=0000", o_valid); end
      total++; if (o_busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
   endtask

   task automatic test_single();
      int exp_runs[3] = '{4, 4, 2};
      int runs[$];
      int gaps[$];
      int run = 0, zeros = 0, nvalid = 0, lag_bad = 0, data_bad = 0, gnt_bad = 0;
      logic prev_en = 1'b0;
      logic [DW-1:0] first, exp_d;
      logic [N-1:0] exp_v;
      fifo_q.delete();
      push(10);
      first = fifo_q[0];
      req = 4'b0001;
      for (int c = 0; c < 40; c++) begin
         step();
         exp_v = prev_en ? 4'b0001 : 4'b0000;
         if (o_valid !== exp_v) lag_bad++;
         if (o_valid != '0) begin
            exp_d = first + DW'(nvalid);
            if (o_data !== exp_d) data_bad++;
            nvalid++;
         end
         if (o_rd_en && o_gnt !== 4'b0001) gnt_bad++;
         if (o_rd_en) begin
            if (run == 0 && runs.size() > 0) gaps.push_back(zeros);
            run++;
            zeros = 0;
         end else begin
            if (run > 0) runs.push_back(run);
            run = 0;
            zeros++;
         end
         prev_en = o_rd_en;
      end
      if (run > 0) runs.push_back(run);
      total++;
      if (runs.size() != 3) begin bad++; $display("FAIL single_burst_count got=%0d exp=3", runs.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (runs[i] != exp_runs[i]) begin bad++; $display("FAIL single_burst_len[%0d] got=%0d exp=%0d", i, runs[i], exp_runs[i]); end
         end
         for (int i = 0; i < 2; i++) begin
            total++;
            if (gaps[i] != 1) begin bad++; $display("FAIL single_gap[%0d] got=%0d exp=1", i, gaps[i]); end
         end
      end
      total++; if (nvalid != 10)  begin bad++; $display("FAIL single_valid_count got=%0d exp=10", nvalid); end
      total++; if (lag_bad != 0)  begin bad++; $display("FAIL single_valid_lag got=%0d exp=0", lag_bad); end
      total++; if (data_bad != 0) begin bad++; $display("FAIL single_data_order got=%0d exp=0", data_bad); end
      total++; if (gnt_bad != 0)  begin bad++; $display("FAIL single_gnt got=%0d exp=0", gnt_bad); end
   endtask

   task automatic test_round_robin();
      int exp_o[5] = '{0, 1, 2, 3, 0};
      int owners[$];
      int runs[$];
      int gaps[$];
      int run = 0, zeros = 0, idx;
      logic [N-1:0] prev_gnt = '0;
      rst = 1'b1;
      req = '0;
      step();
      rst = 1'b0;
      fifo_q.delete();
      push(60);
      req = 4'b1111;
      for (int c = 0; c < 30; c++) begin
         step();
         if (o_gnt != '0 && prev_gnt == '0) begin
            idx = -1;
            for (int b = 0; b < N; b++) if (o_gnt[b]) idx = b;
            owners.push_back(idx);
         end
         if (o_rd_en) begin
            if (run == 0 && runs.size() > 0) gaps.push_back(zeros);
            run++;
            zeros = 0;
         end else begin
            if (run > 0) runs.push_back(run);
            run = 0;
            zeros++;
         end
         prev_gnt = o_gnt;
      end
      total++;
      if (owners.size() < 5 || runs.size() < 5) begin
         bad++;
         $display("FAIL rr_bursts got=%0d exp>=5", runs.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (owners[i] != exp_o[i]) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, owners[i], exp_o[i]); end
            total++;
            if (runs[i] != MB) begin bad++; $display("FAIL rr_burst_len[%0d] got=%0d exp=%0d", i, runs[i], MB); end
         end
         for (int i = 0; i < 4; i++) begin
            total++;
            if (gaps[i] != 1) begin bad++; $display("FAIL rr_gap[%0d] got=%0d exp=1", i, gaps[i]); end
         end
      end
   endtask

   task automatic test_empty_mid();
      int pops = 0, nvalid = 0, vbad = 0, data_bad = 0, empty_pop = 0;
      logic [DW-1:0] first, exp_d;
      req = '0;
      fifo_q.delete();
      step();
      step();
      push(2);
      first = fifo_q[0];
      req = 4'b0010;
      for (int c = 0; c < 15; c++) begin
         step();
         if (o_rd_en) pops++;
         if (o_rd_en && o_empty) empty_pop++;
         if (o_valid != '0) begin
            if (o_valid !== 4'b0010) vbad++;
            exp_d = first + DW'(nvalid);
            if (o_data !== exp_d) data_bad++;
            nvalid++;
         end
      end
      total++; if (pops != 2)      begin bad++; $display("FAIL empty_pops got=%0d exp=2", pops); end
      total++; if (nvalid != 2)    begin bad++; $display("FAIL empty_valid_count got=%0d exp=2", nvalid); end
      total++; if (vbad != 0)      begin bad++; $display("FAIL empty_valid_owner got=%0d exp=0", vbad); end
      total++; if (data_bad != 0)  begin bad++; $display("FAIL empty_data_order got=%0d exp=0", data_bad); end
      total++; if (empty_pop != 0) begin bad++; $display("FAIL empty_pop_while_empty got=%0d exp=0", empty_pop); end
      total++; if (o_gnt !== '0)   begin bad++; $display("FAIL empty_final_gnt got=%b exp=0000", o_gnt); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL empty_final_busy got=%b exp=0", o_busy); end
   endtask

   task automatic test_release();
      logic found = 1'b0;
      rst = 1'b1;
      req = '0;
      step();
      rst = 1'b0;
      fifo_q.delete();
      push(20);
      req = 4'b1100;
      for (int c = 0; c < 10; c++) begin
         step();
         if (o_gnt == 4'b0100) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin bad++; $display("FAIL release_grant2 got=%b exp=0100", o_gnt); end
      total++; if (o_rd_en !== 1'b1) begin bad++; $display("FAIL release_first_pop got=%b exp=1", o_rd_en); end
      req = 4'b1000;
      step();
      total++; if (o_gnt !== 4'b0100) begin bad++; $display("FAIL release_hold_gnt got=%b exp=0100", o_gnt); end
      total++; if (o_rd_en !== 1'b0)  begin bad++; $display("FAIL release_no_pop got=%b exp=0", o_rd_en); end
      step();
      total++; if (o_gnt !== 4'b0000) begin bad++; $display("FAIL release_idle_gnt got=%b exp=0000", o_gnt); end
      step();
      total++; if (o_gnt !== 4'b1000) begin bad++; $display("FAIL release_next_gnt got=%b exp=1000", o_gnt); end
   endtask

   task automatic test_reset_mid();
      logic found = 1'b0;
      req = '0;
      step();
      step();
      fifo_q.delete();
      push(20);
      req = 4'b0100;
      for (int c = 0; c < 10; c++) begin
         step();
         if (o_rd_en) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found || o_gnt !== 4'b0100) begin bad++; $display("FAIL rstmid_first_pop got=%b exp=0100", o_gnt); end
      rst = 1'b1;
      req = 4'b1111;
      step();
      total++; if (o_rd_en !== 1'b0) begin bad++; $display("FAIL rstmid_rd_en got=%b exp=0", o_rd_en); end
      total++; if (o_gnt !== '0)     begin bad++; $display("FAIL rstmid_gnt got=%b exp=0000", o_gnt); end
      total++; if (o_busy !== 1'b0)  begin bad++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
      rst = 1'b0;
      step();
      total++; if (o_valid !== '0) begin bad++; $display("FAIL rstmid_valid_after got=%b exp=0000", o_valid); end
      total++; if (o_gnt !== '0)   begin bad++; $display("FAIL rstmid_idle_gnt got=%b exp=0000", o_gnt); end
      step();
      total++; if (o_gnt !== 4'b0001) begin bad++; $display("FAIL rstmid_priority got=%b exp=0001", o_gnt); end
   endtask

   task automatic test_no_underflow();
      int nz = 0;
      fifo_q.delete();
      req = 4'b1111;
      step();
      step();
      step();
      for (int c = 0; c < 20; c++) begin
         step();
         if (o_rd_en || o_gnt != '0 || o_valid != '0) nz++;
      end
      total++; if (nz != 0)         begin bad++; $display("FAIL empty_idle_activity got=%0d exp=0", nz); end
      total++; if (underflows != 0) begin bad++; $display("FAIL underflow_count got=%0d exp=0", underflows); end
   endtask

   task automatic test_random();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) req = N'($urandom);
         if ($urandom_range(0, 2) == 0) push($urandom_range(1, 3));
         force_empty = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
         total++; if (o_gnt !== e_gnt)     begin bad++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, o_gnt, e_gnt); end
         total++; if (o_rd_en !== e_rd_en) begin bad++; $display("FAIL rand_rd_en cyc=%0d got=%b exp=%b", c, o_rd_en, e_rd_en); end
         total++; if (o_busy !== e_busy)   begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, o_busy, e_busy); end
         if (!e_rst) begin
            total++; if (o_valid !== e_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, o_valid, e_valid); end
            if (e_valid != '0) begin
               total++; if (o_data !== e_data) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, o_data, e_data); end
            end
         end
      end
      rst = 1'b0;
      force_empty = 1'b0;
      total++; if (underflows != 0) begin bad++; $display("FAIL rand_underflow got=%0d exp=0", underflows); end
   endtask

   initial begin
      m_owner     = -1;
      m_last      = N - 1;
      m_pops      = 0;
      m_vowner    = -1;
      m_vdata     = '0;
      rst         = 1'b1;
      req         = '0;
      force_empty = 1'b0;
      rd_data     = '0;
      rd_empty    = 1'b1;
      wr_seq      = '0;
      underflows  = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_empty_mid();
      test_release();
      test_reset_mid();
      test_no_underflow();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
